ll_frame_gen: RTL and testbench

LL_FRAME_GEN -- requirements
Module: ll_frame_gen

---
 rtl/ll_frame_gen_if.sv | 24 ++
 rtl/ll_frame_gen.sv | 168 ++++++++++++++++
 tb/tb_ll_frame_gen.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ll_frame_gen_if.sv
// LocalLink transmit bundle: the frame source drives data and framing,
// the sink answers with its active-low destination-ready.
interface ll_frame_gen_if;
    logic [31:0] DMALLTXD;
    logic [3:0]  DMALLTXREM;
    logic        DMALLTXSOFN;
    logic        DMALLTXEOFN;
    logic        DMALLTXSOPN;
    logic        DMALLTXEOPN;
    logic        DMALLTXSRCRDYN;
    logic        LLDMATXDSTRDYN;

    modport master (
        output DMALLTXD, DMALLTXREM, DMALLTXSOFN, DMALLTXEOFN,
               DMALLTXSOPN, DMALLTXEOPN, DMALLTXSRCRDYN,
        input  LLDMATXDSTRDYN
    );

    modport slave (
        input  DMALLTXD, DMALLTXREM, DMALLTXSOFN, DMALLTXEOFN,
               DMALLTXSOPN, DMALLTXEOPN, DMALLTXSRCRDYN,
        output LLDMATXDSTRDYN
    );
endinterface

// File: rtl/ll_frame_gen.sv
// LocalLink frame generator: an 8-word header followed by the payload words,
// with a single registered output stage that holds its beat while the sink stalls.
module ll_frame_gen #(
    parameter int FLAG_WORD = 4,
    parameter int LEN_WORD  = 5
) (
    input  logic           CPMDMALLCLK,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_flag,
    input  logic [31:0]    cmd_len,
    input  logic [31:0]    pay_data,
    input  logic           pay_valid,
    output logic           pay_rd,
    ll_frame_gen_if.master tx,
    output logic           busy,
    output logic           done,
    output logic [15:0]    frame_cnt
);

    typedef enum logic [1:0] {IDLE, HDR, PAY, DONE} state_t;

    state_t      state_q, state_d;
    logic        armed_q;
    logic [2:0]  flag_q;
    logic [31:0] len_q;
    logic [2:0]  hdr_idx_q;
    logic [16:0] words_left_q;
    logic [15:0] frame_cnt_q;
    logic [31:0] txd_q;
    logic [3:0]  rem_q;
    logic        sofn_q, eofn_q, sopn_q, eopn_q, srcrdyn_q;

    logic        xfer, out_free, accept, pay_first, pay_last;
    logic [16:0] words_total;

    function automatic logic [31:0] hdr_word(input logic [2:0] idx, input logic [2:0] flag,
                                             input logic [31:0] len);
        if (int'(idx) == FLAG_WORD) return {flag, 29'h0};
        if (int'(idx) == LEN_WORD)  return len;
        return 32'h0;
    endfunction

    // A zero length is sent as one full word.
    function automatic logic [16:0] word_count(input logic [17:0] len);
        logic [18:0] sum;
        if (len == 18'h0) return 17'd1;
        sum = {1'b0, len} + 19'd3;
        return sum[18:2];
    endfunction

    function automatic logic [3:0] last_rem(input logic [1:0] len_lo);
        case (len_lo)
            2'd0:    return 4'b0000;
            2'd1:    return 4'b0111;
            2'd2:    return 4'b0011;
            default: return 4'b0001;
        endcase
    endfunction

    assign xfer        = !srcrdyn_q && !tx.LLDMATXDSTRDYN;
    assign out_free    = srcrdyn_q || !tx.LLDMATXDSTRDYN;
    assign accept      = cmd_valid && cmd_ready;
    assign words_total = word_count(len_q[17:0]);
    assign pay_first   = (words_left_q == words_total);
    assign pay_last    = (words_left_q == 17'd1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CPMDMALLCLK or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaulting every comb output first keeps unlisted paths from inferring latches.
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = HDR;
            HDR:  if (xfer && hdr_idx_q == 3'd7) state_d = PAY;
            PAY:  if (xfer && words_left_q == 17'd0) state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        pay_rd    = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = armed_q;
                busy      = 1'b0;
            end
            PAY:  pay_rd = pay_valid && out_free && (words_left_q != 17'd0);
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // armed_q keeps cmd_ready low until the first edge after reset releases.
    always_ff @(posedge CPMDMALLCLK or posedge rst) begin
        if (rst) begin
            armed_q      <= 1'b0;
            flag_q       <= 3'h0;
            len_q        <= 32'h0;
            hdr_idx_q    <= 3'h0;
            words_left_q <= 17'h0;
            frame_cnt_q  <= 16'h0;
            txd_q        <= 32'h0;
            rem_q        <= 4'h0;
            sofn_q       <= 1'b1;
            eofn_q       <= 1'b1;
            sopn_q       <= 1'b1;
            eopn_q       <= 1'b1;
            srcrdyn_q    <= 1'b1;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                IDLE: if (accept) begin
                    flag_q       <= cmd_flag;
                    len_q        <= cmd_len;
                    hdr_idx_q    <= 3'h0;
                    words_left_q <= word_count(cmd_len[17:0]);
                    txd_q        <= hdr_word(3'h0, cmd_flag, cmd_len);
                    rem_q        <= 4'h0;
                    sofn_q       <= 1'b0;
                    srcrdyn_q    <= 1'b0;
                end
                HDR: if (xfer) begin
                    sofn_q <= 1'b1;
                    if (hdr_idx_q == 3'd7) begin
                        srcrdyn_q <= 1'b1;
                    end else begin
                        hdr_idx_q <= hdr_idx_q + 3'd1;
                        txd_q     <= hdr_word(hdr_idx_q + 3'd1, flag_q, len_q);
                    end
                end
                PAY: if (pay_rd) begin
                    txd_q        <= pay_data;
                    srcrdyn_q    <= 1'b0;
                    sopn_q       <= !pay_first;
                    eopn_q       <= !pay_last;
                    eofn_q       <= !pay_last;
                    rem_q        <= pay_last ? last_rem(len_q[1:0]) : 4'h0;
                    words_left_q <= words_left_q - 17'd1;
                end else if (xfer) begin
                    srcrdyn_q <= 1'b1;
                    sopn_q    <= 1'b1;
                    eopn_q    <= 1'b1;
                    eofn_q    <= 1'b1;
                end
                DONE: frame_cnt_q <= frame_cnt_q + 16'd1;
            endcase
        end
    end

    assign tx.DMALLTXD       = txd_q;
    assign tx.DMALLTXREM     = rem_q;
    assign tx.DMALLTXSOFN    = sofn_q;
    assign tx.DMALLTXEOFN    = eofn_q;
    assign tx.DMALLTXSOPN    = sopn_q;
    assign tx.DMALLTXEOPN    = eopn_q;
    assign tx.DMALLTXSRCRDYN = srcrdyn_q;
    assign frame_cnt         = frame_cnt_q;

endmodule

// File: tb/tb_ll_frame_gen.sv
// Randomised bench for ll_frame_gen: each frame is predicted as a list of beats
// from the length/flag rules and compared against what the sink accepts.
module tb_ll_frame_gen;
    localparam int FLAG_WORD = 4;
    localparam int LEN_WORD  = 5;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  rem;
        logic        sofn, eofn, sopn, eopn;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [2:0]  cmd_flag = 3'h0;
    logic [31:0] cmd_len = 32'h0, pay_data = 32'h0;
    logic        pay_valid = 1'b0, pay_rd, busy, done;
    logic [15:0] frame_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_frames = 16'h0;

    ll_frame_gen_if tx();

    ll_frame_gen #(.FLAG_WORD(FLAG_WORD), .LEN_WORD(LEN_WORD)) dut (
        .CPMDMALLCLK(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_flag(cmd_flag), .cmd_len(cmd_len),
        .pay_data(pay_data), .pay_valid(pay_valid), .pay_rd(pay_rd),
        .tx(tx.master),
        .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic beat_t sample_beat();
        beat_t b;
        b.d    = tx.DMALLTXD;
        b.rem  = tx.DMALLTXREM;
        b.sofn = tx.DMALLTXSOFN;
        b.eofn = tx.DMALLTXEOFN;
        b.sopn = tx.DMALLTXSOPN;
        b.eopn = tx.DMALLTXEOPN;
        return b;
    endfunction

    // Snapshot of every output that reset defines: data, rem, 5 LL flags, pay_rd, done, busy, cmd_ready, frame_cnt.
    function automatic logic [60:0] reset_view();
        return {tx.DMALLTXD, tx.DMALLTXREM, tx.DMALLTXSOFN, tx.DMALLTXEOFN, tx.DMALLTXSOPN,
                tx.DMALLTXEOPN, tx.DMALLTXSRCRDYN, pay_rd, done, busy, cmd_ready, frame_cnt};
    endfunction

    // Runs one complete frame with random sink stalls and payload gaps.
    task automatic run_frame(input logic [2:0] flag, input logic [31:0] len, input int stall_pct,
                             input int gap_pct, output int n_rd, output logic [3:0] last_rem_seen);
        beat_t       exp_q[$];
        logic [31:0] src[$];
        beat_t       b, cur, prev;
        int          bytes, w, bi, rd, cyc, budget, phase;
        logic        prev_stall, first;
        bytes = int'(len[17:0]);
        if (bytes == 0) bytes = 4;
        w = (bytes + 3) / 4;
        for (int i = 0; i < 8; i++) begin
            b = '{d: 32'h0, rem: 4'h0, sofn: (i != 0), eofn: 1'b1, sopn: 1'b1, eopn: 1'b1};
            if (i == FLAG_WORD) b.d = 32'(flag) << 29;
            if (i == LEN_WORD)  b.d = len;
            exp_q.push_back(b);
        end
        for (int k = 0; k < w + 4; k++) src.push_back($urandom);
        for (int k = 0; k < w; k++) begin
            b.d    = src[k];
            b.sofn = 1'b1;
            b.sopn = (k != 0);
            b.eopn = (k != w - 1);
            b.eofn = (k != w - 1);
            b.rem  = (k == w - 1) ? 4'((1 << ((4 - bytes % 4) % 4)) - 1) : 4'h0;
            exp_q.push_back(b);
        end

        @(negedge clk);
        cmd_flag  = flag;
        cmd_len   = len;
        cmd_valid = 1'b1;
        pay_valid = 1'b0;
        tx.LLDMATXDSTRDYN = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_idle got=%b exp=1", cmd_ready);
        end
        @(negedge clk);

        bi = 0; rd = 0; cyc = 0; phase = 0; prev_stall = 1'b0; first = 1'b1;
        last_rem_seen = 4'hx;
        budget = 20 * (w + 8) + 50;
        prev = '0;
        while (phase != 3 && cyc < budget) begin
            cmd_valid = (phase == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            cmd_flag  = 3'($urandom);
            cmd_len   = $urandom;
            tx.LLDMATXDSTRDYN = ($urandom_range(0, 99) < stall_pct);
            pay_valid = ($urandom_range(0, 99) >= gap_pct);
            pay_data  = (rd < src.size()) ? src[rd] : $urandom;
            #1;
            cur = sample_beat();
            if (first) begin
                checks++;
                if ({tx.DMALLTXSRCRDYN, cur.sofn} !== 2'b00) begin
                    failures++;
                    $display("FAIL sof_next_cycle srcrdyn,sofn got=%b exp=00", {tx.DMALLTXSRCRDYN, cur.sofn});
                end
                first = 1'b0;
            end
            if (prev_stall) begin
                checks++;
                if (cur !== prev || tx.DMALLTXSRCRDYN !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold got=%h exp=%h", cur, prev);
                end
            end
            if (tx.DMALLTXSRCRDYN === 1'b1) begin
                checks++;
                if ({cur.sofn, cur.eofn, cur.sopn, cur.eopn} !== 4'hF) begin
                    failures++;
                    $display("FAIL idle_flags got=%b exp=1111", {cur.sofn, cur.eofn, cur.sopn, cur.eopn});
                end
            end
            if (pay_rd === 1'b1) rd++;

            if (phase == 0) begin
                checks++;
                if ({busy, cmd_ready, done} !== 3'b100) begin
                    failures++;
                    $display("FAIL busy_status got=%b exp=100", {busy, cmd_ready, done});
                end
                if (tx.DMALLTXSRCRDYN === 1'b0 && tx.LLDMATXDSTRDYN === 1'b0) begin
                    checks++;
                    if (bi >= exp_q.size()) begin
                        failures++;
                        $display("FAIL extra_beat got=%h", cur);
                    end else begin
                        if (cur !== exp_q[bi]) begin
                            failures++;
                            $display("FAIL beat[%0d] got=%h exp=%h", bi, cur, exp_q[bi]);
                        end
                        if (bi == exp_q.size() - 1) begin
                            phase = 1;
                            last_rem_seen = cur.rem;
                        end
                    end
                    bi++;
                end
            end else if (phase == 1) begin
                checks++;
                if ({busy, cmd_ready, done, tx.DMALLTXSRCRDYN} !== 4'b1011) begin
                    failures++;
                    $display("FAIL done_cycle busy,ready,done,srcrdyn got=%b exp=1011",
                             {busy, cmd_ready, done, tx.DMALLTXSRCRDYN});
                end
                exp_frames = exp_frames + 16'd1;
                phase = 2;
            end else begin
                checks++;
                if ({busy, cmd_ready, done} !== 3'b010 || frame_cnt !== exp_frames) begin
                    failures++;
                    $display("FAIL after_done status=%b cnt=%0d exp status=010 cnt=%0d",
                             {busy, cmd_ready, done}, frame_cnt, exp_frames);
                end
                phase = 3;
            end
            prev_stall = (tx.DMALLTXSRCRDYN === 1'b0 && tx.LLDMATXDSTRDYN === 1'b1);
            prev = cur;
            cyc++;
            if (phase != 3) @(negedge clk);
        end
        cmd_valid = 1'b0;
        pay_valid = 1'b0;
        checks++;
        if (phase != 3) begin
            failures++;
            $display("FAIL frame_timeout beats=%0d exp=%0d", bi, exp_q.size());
        end
        checks++;
        if (rd != w) begin
            failures++;
            $display("FAIL pay_rd_count got=%0d exp=%0d", rd, w);
        end
        n_rd = rd;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (reset_view() !== {32'h0, 4'h0, 5'b11111, 4'b0000, 16'h0}) begin
            failures++;
            $display("FAIL reset_values got=%h", reset_view());
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({cmd_ready, busy, tx.DMALLTXSRCRDYN} !== 3'b101) begin
            failures++;
            $display("FAIL ready_after_reset got=%b exp=101", {cmd_ready, busy, tx.DMALLTXSRCRDYN});
        end
    endtask

    task automatic test_basic();
        int n; logic [3:0] r;
        run_frame(3'b001, 32'd10, 0, 0, n, r);
        checks++;
        if (n != 3 || r !== 4'b0011 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL basic rd=%0d rem=%b cnt=%0d exp rd=3 rem=0011 cnt=1", n, r, frame_cnt);
        end
    endtask

    task automatic test_single_word();
        int n; logic [3:0] r;
        run_frame(3'b100, 32'd4, 0, 0, n, r);
        checks++;
        if (n != 1 || r !== 4'b0000) begin
            failures++;
            $display("FAIL len4 rd=%0d rem=%b exp rd=1 rem=0000", n, r);
        end
        run_frame(3'b010, 32'd0, 20, 20, n, r);
        checks++;
        if (n != 1 || r !== 4'b0000) begin
            failures++;
            $display("FAIL len0 rd=%0d rem=%b exp rd=1 rem=0000", n, r);
        end
        run_frame(3'b001, 32'hABC0_0000, 0, 0, n, r);
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL len_hi_zero rd=%0d exp=1", n);
        end
        run_frame(3'b011, 32'hFFFC_0007, 0, 0, n, r);
        checks++;
        if (n != 2 || r !== 4'b0001) begin
            failures++;
            $display("FAIL len_hi_ignored rd=%0d rem=%b exp rd=2 rem=0001", n, r);
        end
    endtask

    task automatic test_stalls();
        int n; logic [3:0] r;
        run_frame(3'b010, 32'd4097, 30, 30, n, r);
        checks++;
        if (n != 1025 || r !== 4'b0111) begin
            failures++;
            $display("FAIL stall_4097 rd=%0d rem=%b exp rd=1025 rem=0111", n, r);
        end
    endtask

    task automatic test_random_frames();
        int n; logic [3:0] r; logic [31:0] len;
        for (int i = 0; i < 6; i++) begin
            len = $urandom;
            len[17:0] = 18'($urandom_range(0, 300));
            run_frame(3'($urandom), len, $urandom_range(0, 50), $urandom_range(0, 50), n, r);
        end
    endtask

    task automatic test_mid_reset();
        int xfers, cyc;
        logic found;
        @(negedge clk);
        cmd_flag = 3'b010; cmd_len = 32'd40; cmd_valid = 1'b1;
        tx.LLDMATXDSTRDYN = 1'b0; pay_valid = 1'b1; pay_data = $urandom;
        @(negedge clk);
        cmd_valid = 1'b0;
        xfers = 0; cyc = 0; found = 1'b0;
        while (!found && cyc < 100) begin
            pay_data = $urandom;
            #1;
            if (tx.DMALLTXSRCRDYN === 1'b0 && xfers == 9) found = 1'b1;
            else begin
                if (tx.DMALLTXSRCRDYN === 1'b0) xfers++;
                cyc++;
                @(negedge clk);
            end
        end
        checks++;
        if (!found || tx.DMALLTXSOPN !== 1'b1) begin
            failures++;
            $display("FAIL reach_pay_word2 found=%b sopn=%b exp found=1 sopn=1", found, tx.DMALLTXSOPN);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (reset_view() !== {32'h0, 4'h0, 5'b11111, 4'b0000, 16'h0}) begin
            failures++;
            $display("FAIL mid_reset_values got=%h", reset_view());
        end
        exp_frames = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        pay_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL ready_after_mid_reset got=%b exp=10", {cmd_ready, busy});
        end
        test_basic();
    endtask

    task automatic test_wrap_back_to_back();
        int needed, done_cnt, cyc, eof_cyc, budget;
        logic finished;
        needed = 65536 - int'(exp_frames);
        budget = needed * 12 + 100;
        done_cnt = 0; cyc = 0; eof_cyc = -1; finished = 1'b0;
        @(negedge clk);
        cmd_flag = 3'b001; cmd_len = 32'd4; cmd_valid = 1'b1;
        tx.LLDMATXDSTRDYN = 1'b0; pay_valid = 1'b1;
        while (!finished && cyc < budget) begin
            pay_data = $urandom;
            #1;
            if (tx.DMALLTXSRCRDYN === 1'b0 && tx.DMALLTXSOFN === 1'b0 && eof_cyc >= 0) begin
                checks++;
                if (cyc - eof_cyc != 3) begin
                    failures++;
                    $display("FAIL eof_to_sof_gap got=%0d exp=3", cyc - eof_cyc);
                end
                eof_cyc = -1;
            end
            if (tx.DMALLTXSRCRDYN === 1'b0 && tx.DMALLTXEOFN === 1'b0) eof_cyc = cyc;
            if (done === 1'b1) begin
                done_cnt++;
                exp_frames = exp_frames + 16'd1;
                if (done_cnt == needed) begin
                    checks++;
                    if (frame_cnt !== 16'hFFFF) begin
                        failures++;
                        $display("FAIL cnt_before_wrap got=%h exp=ffff", frame_cnt);
                    end
                    cmd_valid = 1'b0;
                    finished = 1'b1;
                end
            end
            cyc++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (!finished || frame_cnt !== exp_frames || exp_frames !== 16'h0) begin
            failures++;
            $display("FAIL cnt_wrap finished=%b got=%h exp=0000", finished, frame_cnt);
        end
        pay_valid = 1'b0;
    endtask

    initial begin
        tx.LLDMATXDSTRDYN = 1'b0;
        test_reset();
        test_basic();
        test_single_word();
        test_stalls();
        test_random_frames();
        test_mid_reset();
        test_wrap_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
